// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM and its clear sequencer.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W = 256;

    function automatic logic parity_even(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every RAM address once after reset or on a clear request.
//  state    | meaning
//  ST_CLEAR | writing INIT_VALUE to mem[clr_addr], one entry per cycle
//  ST_IDLE  | user port owns the array
module ram_clear_seq #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    import mem_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: begin
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
        endcase
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_addr = clr_addr_q;

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with req/rvalid handshake and hardware clear sweep.
// Optional stored even parity per entry when RAM_PARITY_EN is defined.
module ram_sync_param #(
    parameter int               WIDTH      = 1,
    parameter int               DEPTH      = 16,
    parameter int               ADDR_W     = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              clear,
    output logic              ready,
    output logic              busy,
    output logic [WIDTH-1:0]  result,
    output logic              rvalid,
    output logic              parity_err
);
    import mem_pkg::*;

`ifdef RAM_PARITY_EN
    localparam int MEM_W = WIDTH + 1;

    function automatic logic [PAR_MAX_W-1:0] widen(input logic [WIDTH-1:0] d);
        widen = '0;
        widen[WIDTH-1:0] = d;
    endfunction
`else
    localparam int MEM_W = WIDTH;
`endif

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic [MEM_W-1:0]  init_word, wr_word, rd_word;
    logic              clr_we, accept, in_range;
    logic [ADDR_W-1:0] clr_addr;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              rvalid_q, rvalid_d;

    ram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Clear wins over a same-cycle request, so it also blocks ready.
    assign ready    = ~busy & ~clear;
    assign accept   = req & ready;
    assign in_range = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));

`ifdef RAM_PARITY_EN
    assign init_word = {parity_even(widen(INIT_VALUE)), INIT_VALUE};
    assign wr_word   = {parity_even(widen(wdata)), wdata};
`else
    assign init_word = INIT_VALUE;
    assign wr_word   = wdata;
`endif

    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = mem_q[address];
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= init_word;
        end else if (accept && write_enable && in_range) begin
            mem_q[address] <= wr_word;
        end
    end

`ifdef RAM_PARITY_EN
    logic perr_q, perr_d;
`endif

    always_comb begin
        result_d = result_q;
        rvalid_d = accept;
`ifdef RAM_PARITY_EN
        perr_d   = 1'b0;
`endif
        if (accept) begin
            if (write_enable) begin
                result_d = wdata;
            end else if (in_range) begin
                result_d = rd_word[WIDTH-1:0];
`ifdef RAM_PARITY_EN
                perr_d   = parity_even(widen(rd_word[WIDTH-1:0])) != rd_word[WIDTH];
`endif
            end else begin
                result_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            rvalid_q <= 1'b0;
`ifdef RAM_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            result_q <= result_d;
            rvalid_q <= rvalid_d;
`ifdef RAM_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign result = result_q;
    assign rvalid = rvalid_q;
`ifdef RAM_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sync_param.sv
// Self-checking bench for ram_sync_param: 8x16 instance for most scenarios, 8x10 for out-of-range.
module tb_ram_sync_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req = 1'b0, we = 1'b0, clear = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       ready, busy, rvalid, perr;
    logic [7:0] result;

    logic       req_b = 1'b0, we_b = 1'b0, clear_b = 1'b0;
    logic [3:0] addr_b = '0;
    logic [7:0] wdata_b = '0;
    logic       ready_b, busy_b, rvalid_b, perr_b;
    logic [7:0] result_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] m16 [16];
    logic [7:0] last16;

    always #5 clk = ~clk;

    ram_sync_param #(.WIDTH(8), .DEPTH(16), .INIT_VALUE(8'h00)) d16 (
        .clk(clk), .rst(rst), .req(req), .write_enable(we), .address(addr),
        .wdata(wdata), .clear(clear), .ready(ready), .busy(busy),
        .result(result), .rvalid(rvalid), .parity_err(perr)
    );

    ram_sync_param #(.WIDTH(8), .DEPTH(10), .INIT_VALUE(8'h00)) d10 (
        .clk(clk), .rst(rst), .req(req_b), .write_enable(we_b), .address(addr_b),
        .wdata(wdata_b), .clear(clear_b), .ready(ready_b), .busy(busy_b),
        .result(result_b), .rvalid(rvalid_b), .parity_err(perr_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m16[i] = 8'h00;
        last16 = 8'h00;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) step();
        tests++; if (busy !== 1'b1)    begin fails++; $display("FAIL rst_busy got=%b exp=1", busy); end
        tests++; if (ready !== 1'b0)   begin fails++; $display("FAIL rst_ready got=%b exp=0", ready); end
        tests++; if (rvalid !== 1'b0)  begin fails++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL rst_result got=%h exp=00", result); end
        tests++; if (perr !== 1'b0)    begin fails++; $display("FAIL rst_perr got=%b exp=0", perr); end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin step(); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL sweep_len got=%0d exp=16", n); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL ready_after_sweep got=%b exp=1", ready); end
        model_reset();
        for (int a = 0; a < 16; a++) begin
            req = 1'b1; we = 1'b0; addr = 4'(a);
            step();
            tests++;
            if (rvalid !== 1'b1 || result !== 8'h00) begin
                fails++; $display("FAIL init_read addr=%0d got=%b/%h exp=1/00", a, rvalid, result);
            end
        end
        req = 1'b0;
        step();
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL idle_rvalid got=%b exp=0", rvalid); end
    endtask

    task automatic test_write_read();
        req = 1'b1; we = 1'b1; addr = 4'd3; wdata = 8'hA5;
        step();
        tests++;
        if (rvalid !== 1'b1 || result !== 8'hA5) begin
            fails++; $display("FAIL write_through got=%b/%h exp=1/a5", rvalid, result);
        end
        we = 1'b0;
        step();
        tests++;
        if (rvalid !== 1'b1 || result !== 8'hA5) begin
            fails++; $display("FAIL read_after_write got=%b/%h exp=1/a5", rvalid, result);
        end
        req = 1'b0;
        step();
        tests++;
        if (rvalid !== 1'b0 || result !== 8'hA5) begin
            fails++; $display("FAIL result_hold got=%b/%h exp=0/a5", rvalid, result);
        end
        m16[3] = 8'hA5;
        last16 = 8'hA5;
    endtask

    task automatic test_out_of_range();
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd12; wdata_b = 8'h11;
        step();
        we_b = 1'b0;
        step();
        tests++;
        if (rvalid_b !== 1'b1 || result_b !== 8'h00) begin
            fails++; $display("FAIL oor_read12 got=%b/%h exp=1/00", rvalid_b, result_b);
        end
        addr_b = 4'd4;
        step();
        tests++; if (result_b !== 8'h00) begin fails++; $display("FAIL oor_alias4 got=%h exp=00", result_b); end
        addr_b = 4'd9;
        step();
        tests++; if (result_b !== 8'h00) begin fails++; $display("FAIL read9_init got=%h exp=00", result_b); end
        we_b = 1'b1; wdata_b = 8'h22;
        step();
        we_b = 1'b0;
        step();
        tests++; if (result_b !== 8'h22) begin fails++; $display("FAIL read9_last got=%h exp=22", result_b); end
        req_b = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic       r, w;
        logic [3:0] a;
        logic [7:0] d;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 3) != 0);
            w = 1'($urandom);
            a = 4'($urandom);
            d = 8'($urandom);
            req = r; we = w; addr = a; wdata = d;
            if (r) begin
                if (w) begin
                    m16[a] = d;
                    last16 = d;
                end else begin
                    last16 = m16[a];
                end
            end
            step();
            tests++;
            if (rvalid !== r || result !== last16) begin
                fails++; $display("FAIL b2b i=%0d got=%b/%h exp=%b/%h", i, rvalid, result, r, last16);
            end
            tests++;
            if (perr !== 1'b0) begin fails++; $display("FAIL b2b_perr i=%0d got=%b exp=0", i, perr); end
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_clear_priority();
        int n;
        req = 1'b1; we = 1'b1; addr = 4'd2; wdata = 8'h77; clear = 1'b1;
        #1;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL clr_ready got=%b exp=0", ready); end
        step();
        clear = 1'b0; req = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clr_busy got=%b exp=1", busy); end
        tests++;
        if (rvalid !== 1'b0 || result !== last16) begin
            fails++; $display("FAIL clr_req_drop got=%b/%h exp=0/%h", rvalid, result, last16);
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin step(); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL clr_sweep_len got=%0d exp=16", n); end
        for (int i = 0; i < 16; i++) m16[i] = 8'h00;
        for (int a = 0; a < 16; a++) begin
            req = 1'b1; we = 1'b0; addr = 4'(a);
            step();
            tests++;
            if (result !== m16[a]) begin fails++; $display("FAIL clr_read addr=%0d got=%h exp=%h", a, result, m16[a]); end
        end
        req = 1'b0;
        last16 = 8'h00;
        step();
    endtask

    task automatic test_reset_midsweep();
        int n;
        req = 1'b1; we = 1'b1; addr = 4'd7; wdata = 8'h5A;
        step();
        addr = 4'd12; wdata = 8'h3C;
        step();
        req = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (7) step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midsweep_busy got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b1 || rvalid !== 1'b0 || result !== 8'h00 || ready !== 1'b0) begin
            fails++; $display("FAIL midsweep_rst got=busy%b rv%b res%h rdy%b exp=busy1 rv0 res00 rdy0",
                              busy, rvalid, result, ready);
        end
        step();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin step(); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL restart_sweep_len got=%0d exp=16", n); end
        model_reset();
        req = 1'b1; we = 1'b0; addr = 4'd7;
        step();
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL restart_read7 got=%h exp=00", result); end
        addr = 4'd12;
        step();
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL restart_read12 got=%h exp=00", result); end
        req = 1'b0;
        step();
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'h0F;
        step();
        tests++; if (perr !== 1'b0) begin fails++; $display("FAIL par_write got=%b exp=0", perr); end
        req = 1'b0;
        step();
        d16.mem_q[5][0] = ~d16.mem_q[5][0];
        req = 1'b1; we = 1'b0; addr = 4'd5;
        step();
        tests++;
        if (perr !== 1'b1 || rvalid !== 1'b1) begin
            fails++; $display("FAIL par_flip got=%b/%b exp=1/1", perr, rvalid);
        end
        addr = 4'd6;
        step();
        tests++; if (perr !== 1'b0) begin fails++; $display("FAIL par_clean got=%b exp=0", perr); end
        req = 1'b0;
        step();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_clear_priority();
        test_reset_midsweep();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
